// File: rtl/async_fifo_wr_ptr_if.sv
// Write-side bus of the async FIFO pointer block.
// Producer-facing signals, the RAM write port and the synchronised read pointer
// are bundled here so the pointer block and its user share one declaration.
// Handshake: wr_accept is combinational from wr_en and the registered full flag;
// a write takes effect on the rising edge of clk where wr_en and wr_accept are
// both high, and a wr_en refused by full is counted as an overflow.
interface async_fifo_wr_ptr_if #(
    parameter int PTR = 4
);
    logic           wr_en;
    logic [PTR:0]   rd_gray_sync;
    logic           wr_accept;
    logic [PTR-1:0] wr_addr;
    logic [PTR:0]   wr_gray;
    logic           full;
    logic           almost_full;
    logic [PTR:0]   wr_level;
    logic           overflow;

    // Producer / environment side
    modport master (
        output wr_en,
        output rd_gray_sync,
        input  wr_accept,
        input  wr_addr,
        input  wr_gray,
        input  full,
        input  almost_full,
        input  wr_level,
        input  overflow
    );

    // Pointer block side
    modport slave (
        input  wr_en,
        input  rd_gray_sync,
        output wr_accept,
        output wr_addr,
        output wr_gray,
        output full,
        output almost_full,
        output wr_level,
        output overflow
    );
endinterface

// File: rtl/async_fifo_wr_ptr.sv
// Write-domain pointer and flag block of the async FIFO.
// Holds the binary write pointer (one extra wrap bit), publishes a registered
// Gray copy for the read-domain synchroniser, and derives full, almost_full,
// fill level and a sticky overflow flag from the synchronised read Gray pointer.
// Flags are computed from the next-state pointer so they are never optimistic;
// they may lag a read by the synchroniser latency.
module async_fifo_wr_ptr #(
    parameter int PTR       = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    async_fifo_wr_ptr_if.slave  bus
);
    localparam int           DEPTH    = 1 << PTR;
    localparam logic [PTR:0] AF_LEVEL = (PTR + 1)'(DEPTH - AF_MARGIN);

    logic [PTR:0] wr_bin_q,  wr_bin_d;
    logic [PTR:0] wr_gray_q, wr_gray_d;
    logic [PTR:0] level_q,   level_d;
    logic         full_q,    full_d;
    logic         af_q,      af_d;
    logic         ovf_q,     ovf_d;
    logic [PTR:0] rd_bin;
    logic         wr_accept;

    // A write is refused only by the registered full flag, so the producer sees no latency
    assign wr_accept = bus.wr_en & ~full_q;

    // Gray-to-binary of the synchronised read pointer: bit i is the XOR of Gray bits PTR..i
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= PTR; i++) begin
            rd_bin[i] = ^(bus.rd_gray_sync >> i);
        end
    end

    // Next-state pointer and flags; a write and a read advance in the same cycle both land here
    always_comb begin
        wr_bin_d  = wr_bin_q + (PTR + 1)'(wr_accept);
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
        // Full when the write pointer is exactly one lap ahead: Gray top two bits inverted
        full_d    = (wr_gray_d == {~bus.rd_gray_sync[PTR:PTR-1], bus.rd_gray_sync[PTR-2:0]});
        level_d   = wr_bin_d - rd_bin;
        af_d      = (level_d >= AF_LEVEL);
        ovf_d     = ovf_q | (bus.wr_en & full_q);
    end

    // Pointer, flag and level registers; reset discards all pointer state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.wr_accept   = wr_accept;
    assign bus.wr_addr     = wr_bin_q[PTR-1:0];
    assign bus.wr_gray     = wr_gray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wr_level    = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_async_fifo_wr_ptr.sv
// Bench for async_fifo_wr_ptr (PTR=4, AF_MARGIN=2).
// The reference model counts writes and reads as plain integers and derives
// level, full and almost_full from their difference.
module tb_async_fifo_wr_ptr;
    localparam int PTR = 4;

    logic clk;
    logic rst_n;

    async_fifo_wr_ptr_if #(.PTR(PTR)) bus ();

    async_fifo_wr_ptr #(.PTR(PTR), .AF_MARGIN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray(input int x);
        logic [4:0] b;
        b = 5'(x);
        return b ^ (b >> 1);
    endfunction

    // ---------------- stimulus state ----------------
    int rd_ptr = 0;   // read pointer as a plain count modulo 32

    // ---------------- reference model ----------------
    int m_wr     = 0;    // accepted writes modulo 32
    int m_level  = 0;
    bit m_full   = 0;
    bit m_af     = 0;
    bit m_ovf    = 0;
    bit m_acc    = 0;    // a write was accepted at the last edge
    bit m_rst    = 1;    // last edge was a reset edge
    bit m_valid  = 0;

    always @(posedge clk) begin : model
        int acc;
        int nwr;
        int lvl;
        if (!rst_n) begin
            m_wr    <= 0;
            m_level <= 0;
            m_full  <= 0;
            m_af    <= 0;
            m_ovf   <= 0;
            m_acc   <= 0;
            m_rst   <= 1;
            m_valid <= 1;
        end else begin
            acc = (bus.wr_en && !m_full) ? 1 : 0;
            nwr = (m_wr + acc) % 32;
            lvl = (nwr - rd_ptr + 32) % 32;
            m_wr    <= nwr;
            m_level <= lvl;
            m_full  <= (lvl == 16);
            m_af    <= (lvl >= 14);
            if (bus.wr_en && m_full) m_ovf <= 1;
            m_acc   <= (acc == 1);
            m_rst   <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [4:0] prev_gray;
    bit         have_prev = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("wr_gray",     bus.wr_gray,     gray(m_wr));
            chk("wr_addr",     bus.wr_addr,     32'(m_wr % 16));
            chk("wr_level",    bus.wr_level,    32'(m_level));
            chk("full",        bus.full,        32'(m_full));
            chk("almost_full", bus.almost_full, 32'(m_af));
            chk("overflow",    bus.overflow,    32'(m_ovf));
            chk("wr_accept",   bus.wr_accept,   32'(bus.wr_en && !m_full));
            if (have_prev && !m_rst)
                chk("gray_step", $countones(bus.wr_gray ^ prev_gray), 32'(m_acc));
            prev_gray <= bus.wr_gray;
            have_prev <= 1;
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit rst_v, input bit we, input int rp);
        rst_n            = rst_v;
        bus.wr_en        = we;
        rd_ptr           = rp;
        bus.rd_gray_sync = gray(rp);
    endtask

    // Advance one clock; inputs change 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        drive(0, 0, 0);
        tick();
        tick();

        // idle after reset
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_gray",  bus.wr_gray,     0);
            chk("idle_level", bus.wr_level,    0);
            chk("idle_flags", {bus.full, bus.almost_full, bus.overflow}, 0);
        end

        // fill 16 entries with the reader stalled at 0
        for (int i = 1; i <= 16; i++) begin
            drive(1, 1, 0);
            #1;
            chk("fill_addr",   bus.wr_addr,   32'(i - 1));
            chk("fill_accept", bus.wr_accept, 1);
            tick();
            if (i == 13) chk("fill_af13", bus.almost_full, 0);
            if (i == 14) begin
                chk("fill_af14",    bus.almost_full, 1);
                chk("fill_level14", bus.wr_level,    14);
            end
            if (i == 15) chk("fill_full15", bus.full, 0);
        end
        chk("full_flag",  bus.full,     1);
        chk("full_gray",  bus.wr_gray,  5'b11000);
        chk("full_level", bus.wr_level, 16);

        // overflow: one refused write
        drive(1, 1, 0);
        #1;
        chk("ovf_accept", bus.wr_accept, 0);
        tick();
        chk("ovf_gray", bus.wr_gray,  5'b11000);
        chk("ovf_flag", bus.overflow, 1);
        drive(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ovf_sticky", bus.overflow, 1);
        end

        // drain one entry: full releases a cycle after the read pointer moves
        drive(1, 0, 1);
        tick();
        chk("drain_full",  bus.full,        0);
        chk("drain_level", bus.wr_level,    15);
        chk("drain_af",    bus.almost_full, 1);
        drive(1, 1, 1);
        tick();
        chk("refill_full", bus.full,    1);
        chk("refill_gray", bus.wr_gray, 5'b11001);

        // read pointer jumps to 8: 17 - 8 = 9 outstanding
        drive(1, 0, 8);
        tick();
        chk("mid_level", bus.wr_level,    9);
        chk("mid_af",    bus.almost_full, 0);
        chk("mid_ovf",   bus.overflow,    1);

        // reset with a write pending; the read side resets alongside
        drive(0, 1, 0);
        tick();
        chk("rst_gray",  bus.wr_gray,  0);
        chk("rst_level", bus.wr_level, 0);
        chk("rst_full",  bus.full,     0);
        chk("rst_ovf",   bus.overflow, 0);
        drive(0, 0, 0);
        tick();

        // wrap: 64 writes with the reader trailing by one entry
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, i % 32);
            #1;
            chk("wrap_addr",   bus.wr_addr,   32'(i % 16));
            chk("wrap_accept", bus.wr_accept, 1);
            tick();
            chk("wrap_level", bus.wr_level, 1);
            if (i == 30) chk("wrap_gray31", bus.wr_gray, 5'b10000);
            if (i == 31) begin
                chk("wrap_gray0", bus.wr_gray, 5'b00000);
                chk("wrap_addr0", bus.wr_addr, 0);
            end
        end

        drive(1, 0, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
